// File: rtl/axi4_mem_slave.sv
// AXI4 slave memory: one burst in flight per channel, byte-strobed writes, R data one cycle after AR.
// aw/w/ar readies stall pseudo-randomly and the first R beat may slip a cycle when AXI_MEM_BACKPRESSURE_EN is defined.
module axi4_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    masterAxi_aw_valid,
  output logic                    masterAxi_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   masterAxi_aw_payload_addr,
  input  logic [7:0]              masterAxi_aw_payload_len,
  input  logic [2:0]              masterAxi_aw_payload_size,
  input  logic [1:0]              masterAxi_aw_payload_burst,
  input  logic                    masterAxi_w_valid,
  output logic                    masterAxi_w_ready,
  input  logic [DATA_WIDTH-1:0]   masterAxi_w_payload_data,
  input  logic [DATA_WIDTH/8-1:0] masterAxi_w_payload_strb,
  input  logic                    masterAxi_w_payload_last,
  output logic                    masterAxi_b_valid,
  input  logic                    masterAxi_b_ready,
  output logic [1:0]              masterAxi_b_payload_resp,
  input  logic                    masterAxi_ar_valid,
  output logic                    masterAxi_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   masterAxi_ar_payload_addr,
  input  logic [7:0]              masterAxi_ar_payload_len,
  input  logic [2:0]              masterAxi_ar_payload_size,
  input  logic [1:0]              masterAxi_ar_payload_burst,
  output logic                    masterAxi_r_valid,
  input  logic                    masterAxi_r_ready,
  output logic [DATA_WIDTH-1:0]   masterAxi_r_payload_data,
  output logic [1:0]              masterAxi_r_payload_resp,
  output logic                    masterAxi_r_payload_last
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * STRB_W);
  localparam logic [2:0] MAX_SIZE    = 3'(LSB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The extra top bit catches addresses below BASE_ADDR as a borrow.
  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return diff[ADDR_WIDTH] | (diff[ADDR_WIDTH-1:0] >= MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] | (size > MAX_SIZE);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_next(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] burst,
                                                      input logic [2:0] size);
    return (burst == 2'b01) ? a + (ADDR_WIDTH'(1) << size) : a;
  endfunction

  logic stall;
  logic r_dly;
`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
  assign r_dly = lfsr[2];
`else
  assign stall = 1'b0;
  assign r_dly = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t w_state, w_state_nxt;

  logic                  aw_rdy_q;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [8:0]            w_cnt;
  logic                  w_err;
  logic                  aw_hs, w_hs, w_beat_last, w_beat_err;

  assign masterAxi_aw_ready       = aw_rdy_q & ~stall;
  assign masterAxi_w_ready        = (w_state == W_DATA) & ~stall;
  assign masterAxi_b_valid        = (w_state == W_RESP);
  assign masterAxi_b_payload_resp = (w_state == W_RESP && w_err) ? RESP_SLVERR : RESP_OKAY;

  assign aw_hs       = masterAxi_aw_valid & masterAxi_aw_ready;
  assign w_hs        = masterAxi_w_valid & masterAxi_w_ready;
  assign w_beat_last = (w_cnt == {1'b0, w_len});
  assign w_beat_err  = burst_bad(w_burst, w_size) | addr_bad(w_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state  <= W_IDLE;
      aw_rdy_q <= 1'b0;
    end else begin
      w_state  <= w_state_nxt;
      aw_rdy_q <= (w_state_nxt == W_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: if (aw_hs) w_state_nxt = W_DATA;
      W_DATA: if (w_hs && w_beat_last) w_state_nxt = W_RESP;
      W_RESP: if (masterAxi_b_ready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // The burst always ends on the beat count; a misplaced w_last only poisons the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_addr  <= masterAxi_aw_payload_addr;
      w_len   <= masterAxi_aw_payload_len;
      w_size  <= masterAxi_aw_payload_size;
      w_burst <= masterAxi_aw_payload_burst;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr  <= addr_next(w_addr, w_burst, w_size);
      w_cnt   <= w_cnt + 9'd1;
      w_err   <= w_err | w_beat_err | (masterAxi_w_payload_last != w_beat_last);
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_beat_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (masterAxi_w_payload_strb[i])
          mem[addr_idx(w_addr)][8*i +: 8] <= masterAxi_w_payload_data[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  r_state_t r_state, r_state_nxt;

  logic                  ar_rdy_q;
  logic [ADDR_WIDTH-1:0] r_addr, ld_addr;
  logic [7:0]            r_len, ld_len;
  logic [2:0]            r_size, ld_size;
  logic [1:0]            r_burst, ld_burst;
  logic [8:0]            r_cnt, ld_cnt;
  logic                  ar_hs, r_hs, r_ld, ld_bad;

  assign masterAxi_ar_ready = ar_rdy_q & ~stall;
  assign masterAxi_r_valid  = (r_state == R_DATA);
  assign ar_hs              = masterAxi_ar_valid & masterAxi_ar_ready;
  assign r_hs               = masterAxi_r_valid & masterAxi_r_ready;
  assign ld_bad             = burst_bad(ld_burst, ld_size) | addr_bad(ld_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= R_IDLE;
      ar_rdy_q <= 1'b0;
    end else begin
      r_state  <= r_state_nxt;
      ar_rdy_q <= (r_state_nxt == R_IDLE);
    end
  end

  // ld_* describe the beat that will be presented next; r_ld loads it into the R registers.
  always_comb begin
    r_state_nxt = r_state;
    r_ld        = 1'b0;
    ld_addr     = r_addr;
    ld_cnt      = r_cnt;
    ld_len      = r_len;
    ld_size     = r_size;
    ld_burst    = r_burst;
    case (r_state)
      R_IDLE: if (ar_hs) begin
        ld_addr     = masterAxi_ar_payload_addr;
        ld_cnt      = '0;
        ld_len      = masterAxi_ar_payload_len;
        ld_size     = masterAxi_ar_payload_size;
        ld_burst    = masterAxi_ar_payload_burst;
        r_ld        = ~r_dly;
        r_state_nxt = r_dly ? R_WAIT : R_DATA;
      end
      R_WAIT: begin
        r_ld        = 1'b1;
        r_state_nxt = R_DATA;
      end
      R_DATA: if (r_hs) begin
        if (masterAxi_r_payload_last) begin
          r_state_nxt = R_IDLE;
        end else begin
          r_ld    = 1'b1;
          ld_addr = addr_next(r_addr, r_burst, r_size);
          ld_cnt  = r_cnt + 9'd1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr                   <= '0;
      r_cnt                    <= '0;
      r_len                    <= '0;
      r_size                   <= '0;
      r_burst                  <= '0;
      masterAxi_r_payload_data <= '0;
      masterAxi_r_payload_resp <= RESP_OKAY;
      masterAxi_r_payload_last <= 1'b0;
    end else begin
      if (ar_hs || r_ld) begin
        r_addr  <= ld_addr;
        r_cnt   <= ld_cnt;
        r_len   <= ld_len;
        r_size  <= ld_size;
        r_burst <= ld_burst;
      end
      if (r_ld) begin
        masterAxi_r_payload_data <= ld_bad ? '0 : mem[addr_idx(ld_addr)];
        masterAxi_r_payload_resp <= ld_bad ? RESP_SLVERR : RESP_OKAY;
        masterAxi_r_payload_last <= (ld_cnt == {1'b0, ld_len});
      end
    end
  end

endmodule

// File: doc/axi4_mem_slave.md
Name: axi4_mem_slave

Overview:
- AXI4 slave memory model that sits directly downstream of the DPI-driven AXI4 master.
- Accepts 128-bit AW/W/B and AR/R bursts and services them from an internal register array with byte-strobe writes.
- Gives the TCP/DPI test path a cycle-accurate target, so the bus master can be exercised without external memory.

Parameters:
- ADDR_WIDTH, 32, AXI address width in bits.
- DATA_WIDTH, 128, data bus width in bits; a power of two, at least 32.
- MEM_WORDS, 1024, memory depth in DATA_WIDTH words; a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_WORDS*DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- masterAxi_aw_valid / masterAxi_aw_ready  in / out  1  write-address handshake.
- masterAxi_aw_payload_addr / _len / _size / _burst  in  ADDR_WIDTH / 8 / 3 / 2  write-address payload.
- masterAxi_w_valid / masterAxi_w_ready  in / out  1  write-data handshake.
- masterAxi_w_payload_data / _strb / _last  in  DATA_WIDTH / DATA_WIDTH/8 / 1  write beat.
- masterAxi_b_valid / masterAxi_b_ready  out / in  1  write-response handshake.
- masterAxi_b_payload_resp  out  2  write response.
- masterAxi_ar_valid / masterAxi_ar_ready  in / out  1  read-address handshake.
- masterAxi_ar_payload_addr / _len / _size / _burst  in  ADDR_WIDTH / 8 / 3 / 2  read-address payload.
- masterAxi_r_valid / masterAxi_r_ready  out / in  1  read-data handshake.
- masterAxi_r_payload_data / _resp / _last  out  DATA_WIDTH / 2 / 1  read beat.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs are 0; both FSMs go to IDLE; memory contents are not cleared.
  - aw_ready and ar_ready are registered and rise on the first clk edge after reset goes high.
  - Reset asserted mid-burst abandons the burst immediately; no B or R is issued for it.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: aw_ready=1. On an AW handshake, latch addr, len, size and burst; clear beat count and the error flag; go to W_DATA.
  - W_DATA: aw_ready=0, w_ready=1. Each W handshake writes the strobed bytes to the current word and then advances the address.
    - Advance rule: FIXED (00) holds the address; INCR (01) adds 1<<size bytes, carrying across the word boundary.
    - After len+1 beats, go to W_RESP.
    - If w_last disagrees with the beat count, set the error flag; the burst still ends on the count.
  - W_RESP: b_valid=1 and holds until b_ready. resp is OKAY (00), or SLVERR (10) if the error flag is set. Return to W_IDLE on the handshake.
- Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ar_ready=1. On an AR handshake, latch addr, len, size and burst.
  - R_DATA: r_valid is asserted 1 cycle after the AR handshake (registered read).
    - data is the word at the current address; r_last=1 on beat len.
    - Beats advance on r_valid & r_ready using the same address rules as writes.
    - When r_ready is low, data, resp and last hold stable.
    - Leave after the last beat handshake; ar_ready returns the following cycle.
- Decode:
  - Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8), truncated modulo MEM_WORDS.
  - An address outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*DATA_WIDTH/8) marks the beat as error: writes are suppressed; reads return data 0 with resp SLVERR.
  - Error is evaluated per beat, so an INCR burst running off the end turns erroneous mid-burst.
  - Any write beat error makes the whole B response SLVERR.
- Unsupported requests: WRAP (10), reserved (11), or size > log2(DATA_WIDTH/8) are accepted and run for the full beat count. Writes are ignored; reads return 0 with SLVERR; B is SLVERR.
- Channel concurrency:
  - Read and write channels are fully independent; one outstanding transaction per channel.
  - A read of a word written in the same cycle returns the old value.
- len=0 is a single beat with last=1. len=255 is 256 beats; the beat counter is 9 bits, with no wrap.

Optional Feature:
- Macro: AXI_MEM_BACKPRESSURE_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle.
  - aw_ready, w_ready and ar_ready are additionally gated low whenever LFSR[1:0]==2'b00.
  - The first R beat is delayed one extra cycle when LFSR[2]=1.
  - Protocol is otherwise unchanged.
- Undefined: no LFSR is present; readies and latency are exactly as in Behaviour.

Test Plan:
- Single beat, in order:
  - AW addr=0x10, len=0, size=4, INCR; W data=0x0123..CDEF, strb=16'hFFFF, last=1 -> B resp=00.
  - Then AR addr=0x10, len=0 -> R data=0x0123..CDEF, resp=00, last=1, r_valid 1 cycle after ar handshake.
- Partial strobe: write strb=16'h000F with data=0xAAAA... over a word of all ones -> readback has bytes 0-3 = 0xAA and bytes 4-15 = 0xFF.
- INCR burst with backpressure:
  - AW addr=0x100, len=3 with beats D0..D3, then AR addr=0x100, len=3.
  - r_ready toggled 1,0,1,0 -> D0..D3 in order; last only on the 4th beat; data stable while r_ready=0.
- Out of range: INCR len=1 starting at the final word (BASE_ADDR + MEM_WORDS*16 - 16) -> write B=SLVERR with the final word updated; read returns beat0 OKAY, beat1 data 0 with SLVERR.
- Unsupported burst: AR burst=2'b10, len=1 -> two beats, data 0, resp SLVERR, last on beat 2; the write channel is unaffected.
- Reset mid-burst: assert reset after beat 1 of a len=3 write -> b_valid stays 0. After release, aw_ready=1 on the first edge, and a new single-beat write completes with resp=00.
